mult_share_arbiter: RTL and testbench
=====================================

// Module: mult_share_arbiter
// PURPOSE
//  Shares one combinational 4x4 array multiplier between two requesters.
//  Round-robin arbitration selects a requester and latches its operands into DFFs.
//  The registered 8-bit product is returned on a single response channel, tagged with the requester id.
//  Sits between the Basys3 switch/button front-end (two operand sources) and the display path.
// PARAMETERS
//  WIDTH       4  operand width; only 4 is legal (product width 2*WIDTH = 8)
//  FIRST_PRIO  0  requester that wins the first contested grant after reset (0 or 1)
// PORTS
//  clk        in   1  single clock; all state updates on rising edge
//  rst_n      in   1  synchronous, active-low reset
//  req_valid  in   2  bit i: requester i presents operands
//  req_ready  out  2  bit i: requester i accepted this cycle (one-hot or zero)
//  req_x0     in   4  requester 0 multiplicand
//  req_y0     in   4  requester 0 multiplier
//  req_x1     in   4  requester 1 multiplicand
//  req_y1     in   4  requester 1 multiplier
//  rsp_valid  out  1  product available
//  rsp_ready  in   1  consumer takes product
//  rsp_id     out  1  requester that owns rsp_z
//  rsp_z      out  8  registered product x*y
//  busy       out  1  high in any state other than IDLE
//  op_count   out  8  count of completed responses, wraps 255->0
// BEHAVIOUR
//  Reset (rst_n=0 at an edge):
//   - state=IDLE; op_x/op_y/rsp_z=0, rsp_id=0, rsp_valid=0, op_count=0
//   - last_grant=~FIRST_PRIO; in-flight operation discarded, no response issued
//  FSM, 3 states:
//   - IDLE -> CALC on request handshake
//   - CALC -> RESP unconditionally
//   - RESP -> IDLE on rsp_valid&&rsp_ready
//  Grant (combinational, IDLE only):
//   - one valid -> that requester
//   - both valid -> requester != last_grant
//   - req_ready = onehot(grant) in IDLE, 0 in CALC/RESP
//  Handshake on req_valid[i]&&req_ready[i] at edge N:
//   - op_x<=req_xi, op_y<=req_yi, id<=i, last_grant<=i, state<=CALC
//  CALC (cycle N+1):
//   - multiplier driven only from op_x/op_y
//   - at edge end of N+1: rsp_z<=product, rsp_id<=id, state<=RESP
//  RESP: rsp_valid=1 from cycle N+2; latency request-handshake -> rsp_valid = 2 cycles
//  Backpressure:
//   - while rsp_valid&&!rsp_ready: rsp_z, rsp_id, rsp_valid held stable
//   - no new request accepted
//  Response handshake: op_count+=1 (mod 256), state<=IDLE
//   - next request acceptable the following cycle
//   - max throughput 1 product per 3 cycles
//  Requester rule: valid and data held until ready; arbiter re-evaluates every IDLE cycle and tolerates a drop.
//  Arithmetic: product = unsigned x*y, max 15*15 = 225 (8'hE1); no overflow possible.
//  busy = (state!=IDLE); rsp_valid = (state==RESP); both registered-state decodes, no comb path from inputs.
// STRUCTURE
//  Shared package (mult_pkg):
//   - state encoding localparams ST_IDLE=2'd0, ST_CALC=2'd1, ST_RESP=2'd2
//   - MULT_W=4, PROD_W=8
//  One sub-module: multiplier_4bit (existing gate-level array multiplier), instanced once as the shared resource.
//  Remaining logic (arbiter, FSM, operand/result DFFs, counter) stays in this module.
// TESTING
//  1. After reset, req0 {x=15,y=15} only, rsp_ready=1
//     -> req_ready=2'b01 at N, rsp_valid at N+2, rsp_z=8'hE1, rsp_id=0, op_count=1
//  2. Both valid from reset, x0=3,y0=5 / x1=7,y1=9, FIRST_PRIO=0
//     -> rsp 15 id0, then rsp 63 id1, then id0 again (alternation)
//  3. rsp_ready=0 for 5 cycles during RESP with req1 pending
//     -> rsp_z/rsp_id stable, req_ready=0 throughout, req1 granted the cycle after release
//  4. rst_n=0 for one edge in CALC
//     -> next cycle IDLE, rsp_valid=0, rsp_z=0, op_count unchanged at 0, no response ever for that request
//  5. Exhaustive 256 operand pairs alternated over both requesters
//     -> every rsp_z == x*y with correct rsp_id; op_count wraps to 0 after 256th response
//  6. req_valid drops while in IDLE before grant
//     -> no handshake, state stays IDLE, busy=0

Source files
------------

// File: rtl/mult_share_arbiter_pkg.sv
// mult_pkg: shared state encoding and widths for the shared-multiplier arbiter
package mult_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam int MULT_W = 4;
  localparam int PROD_W = 8;
  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_CALC = ST_CALC,
    S_RESP = ST_RESP
  } state_t;
endpackage

// File: rtl/mult_share_arbiter_mult.sv
// multiplier_4bit: unsigned combinational array multiplier built from AND partial products and full-adder rows
module multiplier_4bit
  import mult_pkg::*;
(
  input  logic [MULT_W-1:0] x,
  input  logic [MULT_W-1:0] y,
  output logic [PROD_W-1:0] z
);
  // Each row adds the next partial product to the previous row shifted right; the bit shifted out is final
  always_comb begin
    logic [MULT_W:0] acc;
    logic c, a, b;
    z = '0;
    c = 1'b0;
    a = 1'b0;
    b = 1'b0;
    acc = {1'b0, x & {MULT_W{y[0]}}};
    for (int i = 1; i < MULT_W; i++) begin
      z[i-1] = acc[0];
      c = 1'b0;
      for (int j = 0; j < MULT_W; j++) begin
        a = acc[j+1];
        b = x[j] & y[i];
        acc[j] = a ^ b ^ c;
        c = (a & b) | (c & (a ^ b));
      end
      acc[MULT_W] = c;
    end
    z[PROD_W-1:MULT_W-1] = acc;
  end
endmodule

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin sharing of one 4x4 multiplier between two requesters with a tagged response
module mult_share_arbiter
  import mult_pkg::*;
#(
  parameter int WIDTH      = MULT_W,
  parameter bit FIRST_PRIO = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [WIDTH-1:0]     req_x0,
  input  logic [WIDTH-1:0]     req_y0,
  input  logic [WIDTH-1:0]     req_x1,
  input  logic [WIDTH-1:0]     req_y1,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [2*WIDTH-1:0]   rsp_z,
  output logic                 busy,
  output logic [7:0]           op_count
);
  state_t             state;
  logic [WIDTH-1:0]   op_x, op_y;
  logic               id, last_grant;
  logic [2*WIDTH-1:0] product;
  multiplier_4bit u_mult (
    .x(op_x),
    .y(op_y),
    .z(product)
  );
  // Grant only in IDLE; on contention the requester that did not win last time goes next
  always_comb begin
    req_ready = 2'b00;
    if (state == S_IDLE)
      req_ready = &req_valid ? (last_grant ? 2'b01 : 2'b10) : req_valid;
  end
  // Status outputs decode registered state only, so there is no input-to-output path
  always_comb begin
    busy      = state != S_IDLE;
    rsp_valid = state == S_RESP;
  end
  // Accept -> latch operands, compute for one cycle, hold the product until the consumer takes it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      op_x       <= '0;
      op_y       <= '0;
      id         <= 1'b0;
      last_grant <= ~FIRST_PRIO;
      rsp_z      <= '0;
      rsp_id     <= 1'b0;
      op_count   <= '0;
    end else begin
      case (state)
        S_IDLE: if (|req_ready) begin
          op_x       <= req_ready[1] ? req_x1 : req_x0;
          op_y       <= req_ready[1] ? req_y1 : req_y0;
          id         <= req_ready[1];
          last_grant <= req_ready[1];
          state      <= S_CALC;
        end
        S_CALC: begin
          rsp_z  <= product;
          rsp_id <= id;
          state  <= S_RESP;
        end
        S_RESP: if (rsp_ready) begin
          op_count <= op_count + 8'd1;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: table vectors, corner sequences and a cycle scoreboard for the shared multiplier
module tb_mult_share_arbiter;
  localparam bit FP = 1'b0;
  typedef struct packed { logic id; logic [7:0] z; } rsp_t;
  typedef struct { logic [1:0] v; logic [3:0] x0, y0, x1, y1; logic eid; logic [7:0] ez; } vec_t;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic [1:0] req_valid = 2'b00;
  logic [3:0] req_x0 = '0, req_y0 = '0, req_x1 = '0, req_y1 = '0;
  logic       rsp_ready = 1'b1;
  logic [1:0] req_ready;
  logic       rsp_valid, rsp_id, busy;
  logic [7:0] rsp_z, op_count;
  int         n_tests = 0, n_fail = 0;
  bit         chk_on = 1'b0;
  rsp_t       sbq[$];
  int         m_st = 0;
  logic       m_last = ~FP, m_id = 1'b0;
  logic [7:0] m_z = '0, m_cnt = '0;

  mult_share_arbiter #(.WIDTH(4), .FIRST_PRIO(FP)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_x0(req_x0), .req_y0(req_y0), .req_x1(req_x1), .req_y1(req_y1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_z(rsp_z),
    .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_grant(input int st, input logic [1:0] v, input logic last);
    if (st != 0 || v == 2'b00) return 2'b00;
    if (v == 2'b11) return last ? 2'b01 : 2'b10;
    return v;
  endfunction

  // Reference model: advances on each edge from the bench-driven inputs only
  always @(posedge clk) begin
    logic [1:0] g;
    g = exp_grant(m_st, req_valid, m_last);
    if (!rst_n) begin
      m_st = 0; m_last = ~FP; m_z = '0; m_id = 1'b0; m_cnt = '0;
      sbq.delete();
    end else if (m_st == 0) begin
      if (g != 2'b00) begin
        sbq.push_back(g[1] ? rsp_t'{1'b1, 8'(req_x1) * 8'(req_y1)}
                           : rsp_t'{1'b0, 8'(req_x0) * 8'(req_y0)});
        m_last = g[1];
        m_st = 1;
      end
    end else if (m_st == 1) begin
      if (sbq.size() > 0) {m_id, m_z} = sbq.pop_front();
      m_st = 2;
    end else if (rsp_ready) begin
      m_cnt = m_cnt + 8'd1;
      m_st = 0;
    end
  end

  // Every cycle, compare all outputs against the model away from the active edge
  always @(negedge clk) begin
    if (chk_on) begin
      check("req_ready", 32'(req_ready), 32'(exp_grant(m_st, req_valid, m_last)));
      check("busy", 32'(busy), 32'(m_st != 0));
      check("rsp_valid", 32'(rsp_valid), 32'(m_st == 2));
      check("rsp_z", 32'(rsp_z), 32'(m_z));
      check("rsp_id", 32'(rsp_id), 32'(m_id));
      check("op_count", 32'(op_count), 32'(m_cnt));
    end
  end

  task automatic apply_reset();
    rst_n = 1'b0;
    req_valid = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic issue(input logic [1:0] v, input logic [3:0] a0, b0, a1, b1, output logic gid);
    bit got = 1'b0;
    req_valid = v; req_x0 = a0; req_y0 = b0; req_x1 = a1; req_y1 = b1;
    gid = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (|(req_valid & req_ready)) begin
        got = 1'b1;
        gid = req_ready[1];
      end
    end
    if (!got) check("handshake timeout", 0, 1);
    @(posedge clk);
    #1 req_valid = 2'b00;
  endtask

  task automatic await_rsp(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 20);
  endtask

  task automatic run_one(input string tag, input logic [1:0] v, input logic [3:0] a0, b0, a1, b1,
                         input logic eid, input logic [7:0] ez, input logic [7:0] ecnt);
    logic gid;
    int   lat;
    issue(v, a0, b0, a1, b1, gid);
    check({tag, " grant"}, 32'(gid), 32'(eid));
    await_rsp(lat);
    check({tag, " latency"}, lat, 2);
    check({tag, " z"}, 32'(rsp_z), 32'(ez));
    check({tag, " id"}, 32'(rsp_id), 32'(eid));
    @(posedge clk);
    #1;
    check({tag, " count"}, 32'(op_count), 32'(ecnt));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    logic gid;
    int   lat;
    tbl[0] = '{2'b11, 4'd3,  4'd5,  4'd7,  4'd9,  1'b0, 8'd15};
    tbl[1] = '{2'b11, 4'd3,  4'd5,  4'd7,  4'd9,  1'b1, 8'd63};
    tbl[2] = '{2'b11, 4'd3,  4'd5,  4'd7,  4'd9,  1'b0, 8'd15};
    tbl[3] = '{2'b01, 4'd15, 4'd15, 4'd0,  4'd0,  1'b0, 8'hE1};
    tbl[4] = '{2'b10, 4'd0,  4'd0,  4'd15, 4'd1,  1'b1, 8'd15};
    tbl[5] = '{2'b11, 4'd0,  4'd9,  4'd4,  4'd4,  1'b0, 8'd0};
    tbl[6] = '{2'b10, 4'd0,  4'd0,  4'd12, 4'd13, 1'b1, 8'd156};
    tbl[7] = '{2'b01, 4'd1,  4'd1,  4'd0,  4'd0,  1'b0, 8'd1};

    apply_reset();
    chk_on = 1'b1;
    @(negedge clk);
    check("reset busy", 32'(busy), 0);
    check("reset rsp_valid", 32'(rsp_valid), 0);
    check("reset rsp_z", 32'(rsp_z), 0);
    check("reset op_count", 32'(op_count), 0);
    check("reset req_ready", 32'(req_ready), 0);
    @(posedge clk);
    #1;

    for (int k = 0; k < 8; k++)
      run_one($sformatf("vec%0d", k), tbl[k].v, tbl[k].x0, tbl[k].y0, tbl[k].x1, tbl[k].y1,
              tbl[k].eid, tbl[k].ez, 8'(k + 1));

    apply_reset();
    run_one("single req0", 2'b01, 4'd15, 4'd15, 4'd0, 4'd0, 1'b0, 8'hE1, 8'd1);

    rsp_ready = 1'b0;
    issue(2'b01, 4'd5, 4'd6, 4'd0, 4'd0, gid);
    check("bp grant", 32'(gid), 0);
    req_valid = 2'b10; req_x1 = 4'd9; req_y1 = 4'd9;
    await_rsp(lat);
    check("bp latency", lat, 2);
    for (int i = 0; i < 5; i++) begin
      check("bp z held", 32'(rsp_z), 30);
      check("bp id held", 32'(rsp_id), 0);
      check("bp no accept", 32'(req_ready), 0);
      check("bp valid held", 32'(rsp_valid), 1);
      @(negedge clk);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    check("bp release valid", 32'(rsp_valid), 1);
    @(negedge clk);
    check("bp regrant", 32'(req_ready), 32'(2'b10));
    @(posedge clk);
    #1 req_valid = 2'b00;
    await_rsp(lat);
    check("bp2 latency", lat, 2);
    check("bp2 z", 32'(rsp_z), 81);
    check("bp2 id", 32'(rsp_id), 1);
    @(posedge clk);
    #1;

    req_valid = 2'b01; req_x0 = 4'd2; req_y0 = 4'd2;
    @(negedge clk);
    check("drop offer", 32'(req_ready), 32'(2'b01));
    #1 req_valid = 2'b00;
    @(negedge clk);
    check("drop busy", 32'(busy), 0);
    check("drop ready", 32'(req_ready), 0);
    @(posedge clk);
    #1;

    issue(2'b01, 4'd3, 4'd3, 4'd0, 4'd0, gid);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("calc rst busy", 32'(busy), 0);
    check("calc rst valid", 32'(rsp_valid), 0);
    check("calc rst z", 32'(rsp_z), 0);
    check("calc rst count", 32'(op_count), 0);
    repeat (6) begin
      @(negedge clk);
      check("calc rst no rsp", 32'(rsp_valid), 0);
    end
    @(posedge clk);
    #1;

    apply_reset();
    for (int k = 0; k < 256; k++) begin
      logic [7:0] kk;
      logic       r;
      kk = 8'(k);
      r = kk[0];
      run_one($sformatf("ex%0d", k), r ? 2'b10 : 2'b01, kk[7:4], kk[3:0], kk[7:4], kk[3:0],
              r, 8'(kk[7:4]) * 8'(kk[3:0]), 8'(k + 1));
    end
    check("wrap count", 32'(op_count), 0);

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
